// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared address map and region decode for the memory/IO responder
package mem_io_responder_pkg;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_REGION    = 2'b11;
    localparam logic [1:0]  NONE_REGION  = 2'b10;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_NONE,
        RGN_IO
    } region_e;

    // Top two address bits pick RAM (00/01), nothing (10) or the IO window (11).
    function automatic region_e region_of(input logic [17:0] a);
        return (a[17:16] == IO_REGION)   ? RGN_IO :
               (a[17:16] == NONE_REGION) ? RGN_NONE : RGN_RAM;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU byte bus plus UART RX/TX handshakes between CPU side and responder
interface mem_io_responder_if;

    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        cpu_rdy;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        tx_overflow;

    modport master (
        output mem_a, mem_dout, mem_wr, uart_rx_valid, uart_rx_data, uart_tx_ready,
        input  mem_din, io_buffer_full, cpu_rdy, uart_rx_ready, uart_tx_valid,
               uart_tx_data, tx_overflow
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr, uart_rx_valid, uart_rx_data, uart_tx_ready,
        output mem_din, io_buffer_full, cpu_rdy, uart_rx_ready, uart_tx_valid,
               uart_tx_data, tx_overflow
    );

endinterface

// File: rtl/mem_io_tx_fifo.sv
// mem_io_tx_fifo: byte FIFO feeding the UART transmitter, with sticky overflow flag
module mem_io_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  empty,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   count_next
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            data_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full, do_push, do_pop;

    assign full       = count_q == CW'(DEPTH);
    assign empty      = count_q == '0;
    assign head       = data_q[rd_ptr_q];
    assign overflow   = overflow_q;
    assign count_next = count_d;

    // A pop frees a slot in the same cycle, so push while full succeeds only alongside a pop.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(do_push);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(do_pop);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        overflow_d = overflow_q || (push && !do_push);
    end

    // Pointer, count and overflow state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; empty/count gate what is visible.
    always_ff @(posedge clk_in) begin
        if (do_push) data_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM, UART and cycle-counter IO window behind the CPU byte bus
module mem_io_responder #(
    parameter int    RAM_ADDR_WIDTH = 17,
    parameter int    TX_DEPTH_LOG2  = 4,
    parameter int    FULL_MARGIN    = 2,
    parameter string INIT_FILE      = ""
) (
    input  logic             clk_in,
    input  logic             rst_in,
    mem_io_responder_if.slave bus
);

    import mem_io_responder_pkg::*;

    localparam int CW = TX_DEPTH_LOG2 + 1;

    logic [7:0]  ram [2**RAM_ADDR_WIDTH];
    logic [17:0] a;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    region_e     rgn;
    logic        wr_en, ram_we, uart_sel, clk_sel, clk_base, rd;
    logic        push, pop, tx_empty, tx_overflow;
    logic [7:0]  push_data, tx_head, snap_byte;
    logic [CW-1:0] count_next;
    logic        unused_addr;

    logic [7:0]  mem_din_q, mem_din_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
    logic        halted_q, halted_d;
    logic        io_full_q, io_full_d;

    assign a           = bus.mem_a[17:0];
    assign unused_addr = ^bus.mem_a[31:18];
    assign ram_idx     = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign rgn         = region_of(a);
    assign rd          = !bus.mem_wr;
    assign wr_en       = bus.mem_wr && !halted_q;
    assign ram_we      = wr_en && rgn == RGN_RAM;
    assign uart_sel    = rgn == RGN_IO && a[2:0] == IO_UART_ADDR[2:0];
    assign clk_sel     = rgn == RGN_IO && a[2] == IO_CLK_ADDR[2];
    assign clk_base    = clk_sel && a[1:0] == IO_CLK_ADDR[1:0];
    assign snap_byte   = snap_q[{a[1:0], 3'b000} +: 8];

    // A stop write queues a 0x00 marker; a zero byte written to the UART is not queued.
    assign push      = wr_en && ((uart_sel && bus.mem_dout != 8'h00) || clk_base);
    assign push_data = clk_base ? 8'h00 : bus.mem_dout;
    assign pop       = !tx_empty && bus.uart_tx_ready;

    mem_io_tx_fifo #(
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (tx_head),
        .empty      (tx_empty),
        .overflow   (tx_overflow),
        .count_next (count_next)
    );

    assign bus.mem_din        = mem_din_q;
    assign bus.io_buffer_full = io_full_q;
    assign bus.cpu_rdy        = !halted_q;
    assign bus.uart_rx_ready  = !rx_full_q;
    assign bus.uart_tx_valid  = !tx_empty;
    assign bus.uart_tx_data   = tx_head;
    assign bus.tx_overflow    = tx_overflow;

    // Read mux, RX holding register, counter snapshot, halt and near-full flag.
    always_comb begin
        mem_din_d = mem_din_q;
        if (rd) mem_din_d = (rgn == RGN_RAM) ? ram[ram_idx] :
                            uart_sel         ? (rx_full_q ? rx_data_q : 8'h00) :
                            clk_base         ? cyc_q[7:0] :
                            clk_sel          ? snap_byte : 8'h00;
        rx_full_d = rx_full_q ? !(rd && uart_sel) : bus.uart_rx_valid;
        rx_data_d = (!rx_full_q && bus.uart_rx_valid) ? bus.uart_rx_data : rx_data_q;
        cyc_d     = cyc_q + 32'd1;
        snap_d    = (rd && clk_base) ? cyc_q : snap_q;
        halted_d  = halted_q || (bus.mem_wr && clk_base);
        io_full_d = count_next >= CW'((1 << TX_DEPTH_LOG2) - FULL_MARGIN);
    end

    // Register state with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= 8'h00;
            rx_full_q <= 1'b0;
            rx_data_q <= 8'h00;
            cyc_q     <= 32'd0;
            snap_q    <= 32'd0;
            halted_q  <= 1'b0;
            io_full_q <= 1'b0;
        end else begin
            mem_din_q <= mem_din_d;
            rx_full_q <= rx_full_d;
            rx_data_q <= rx_data_d;
            cyc_q     <= cyc_d;
            snap_q    <= snap_d;
            halted_q  <= halted_d;
            io_full_q <= io_full_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_idx] <= bus.mem_dout;
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed checks of RAM, decode, TX FIFO, RX holding, counter and halt
module tb_mem_io_responder;

    logic clk, rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q [16];

    mem_io_responder_if bus();

    mem_io_responder dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic w, input logic [7:0] d);
        bus.mem_a    = addr;
        bus.mem_wr   = w;
        bus.mem_dout = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_din"},   32'(bus.mem_din), 32'h00);
        check({tag, "_txv"},   32'(bus.uart_tx_valid), 32'd0);
        check({tag, "_full"},  32'(bus.io_buffer_full), 32'd0);
        check({tag, "_rdy"},   32'(bus.cpu_rdy), 32'd1);
        check({tag, "_ovf"},   32'(bus.tx_overflow), 32'd0);
        check({tag, "_rxrdy"}, 32'(bus.uart_rx_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 8'h00);
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_tx_ready = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        step();
        drive(32'h30004, 1'b0, 8'h00);
        step();
        check("cnt_start", 32'(bus.mem_din), 32'd2);

        // RAM write/read and unmapped region
        drive(32'h00100, 1'b1, 8'hAB);
        step();
        drive(32'h00010, 1'b1, 8'h11);
        step();
        drive(32'h20010, 1'b1, 8'h55);
        step();
        drive(32'h00100, 1'b0, 8'h00);
        step();
        check("ram_rd", 32'(bus.mem_din), 32'hAB);
        drive(32'h00010, 1'b0, 8'h00);
        step();
        check("unmap_wr_drop", 32'(bus.mem_din), 32'h11);
        drive(32'h20010, 1'b0, 8'h00);
        step();
        check("unmap_rd", 32'(bus.mem_din), 32'h00);

        // fill TX FIFO to the near-full threshold
        for (int i = 1; i <= 14; i++) begin
            drive(32'h30000, 1'b1, 8'h41);
            step();
            if (i == 13) check("full_at13", 32'(bus.io_buffer_full), 32'd0);
            if (i == 14) check("full_at14", 32'(bus.io_buffer_full), 32'd1);
        end
        check("txv_filled", 32'(bus.uart_tx_valid), 32'd1);
        drive(32'h30000, 1'b1, 8'h00);
        step();
        check("zero_ignored_full", 32'(bus.io_buffer_full), 32'd1);
        drive(32'h30000, 1'b1, 8'h42);
        step();
        check("ovf_at15", 32'(bus.tx_overflow), 32'd0);
        drive(32'h30000, 1'b1, 8'h43);
        step();
        check("ovf_at16", 32'(bus.tx_overflow), 32'd0);
        drive(32'h30000, 1'b1, 8'h44);
        step();
        check("ovf_at17", 32'(bus.tx_overflow), 32'd1);
        drive(32'h0, 1'b0, 8'h00);

        // drain in order
        for (int i = 0; i < 14; i++) exp_q[i] = 8'h41;
        exp_q[14] = 8'h42;
        exp_q[15] = 8'h43;
        bus.uart_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_v%0d", i), 32'(bus.uart_tx_valid), 32'd1);
            check($sformatf("drain_d%0d", i), 32'(bus.uart_tx_data), 32'(exp_q[i]));
            step();
            check($sformatf("drain_full%0d", i), 32'(bus.io_buffer_full), 32'((15 - i) >= 14));
        end
        check("drain_empty", 32'(bus.uart_tx_valid), 32'd0);
        check("ovf_sticky", 32'(bus.tx_overflow), 32'd1);
        bus.uart_tx_ready = 1'b0;

        // counter snapshot
        force dut.cyc_q = 32'h12345678;
        drive(32'h30004, 1'b0, 8'h00);
        step();
        release dut.cyc_q;
        check("snap_b0", 32'(bus.mem_din), 32'h78);
        drive(32'h30005, 1'b0, 8'h00);
        step();
        check("snap_b1", 32'(bus.mem_din), 32'h56);
        drive(32'h30006, 1'b0, 8'h00);
        step();
        check("snap_b2", 32'(bus.mem_din), 32'h34);
        drive(32'h30007, 1'b0, 8'h00);
        step();
        check("snap_b3", 32'(bus.mem_din), 32'h12);
        drive(32'h30001, 1'b0, 8'h00);
        step();
        check("io_other_rd", 32'(bus.mem_din), 32'h00);

        // async reset mid-drain
        for (int i = 1; i <= 8; i++) begin
            drive(32'h30000, 1'b1, 8'(8'h60 + i));
            step();
        end
        drive(32'h00100, 1'b0, 8'h00);
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h33;
        bus.uart_tx_ready = 1'b1;
        step();
        bus.uart_rx_valid = 1'b0;
        step();
        step();
        check("pre_rst_head", 32'(bus.uart_tx_data), 32'h64);
        check("pre_rst_din", 32'(bus.mem_din), 32'hAB);
        check("pre_rst_rx", 32'(bus.uart_rx_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst_n = 1'b1;
        bus.uart_tx_ready = 1'b0;
        step();
        step();
        drive(32'h30004, 1'b0, 8'h00);
        step();
        check("cnt_after_rst", 32'(bus.mem_din), 32'd2);
        drive(32'h00100, 1'b0, 8'h00);
        step();
        check("ram_retained", 32'(bus.mem_din), 32'hAB);

        // RX holding, then program stop
        bus.uart_rx_data  = 8'h5A;
        bus.uart_rx_valid = 1'b1;
        check("rx_rdy_empty", 32'(bus.uart_rx_ready), 32'd1);
        step();
        bus.uart_rx_valid = 1'b0;
        check("rx_rdy_loaded", 32'(bus.uart_rx_ready), 32'd0);
        drive(32'h30000, 1'b0, 8'h00);
        step();
        check("rx_read", 32'(bus.mem_din), 32'h5A);
        check("rx_rdy_cleared", 32'(bus.uart_rx_ready), 32'd1);
        step();
        check("rx_read_empty", 32'(bus.mem_din), 32'h00);
        drive(32'h30004, 1'b1, 8'h99);
        step();
        check("stop_txv", 32'(bus.uart_tx_valid), 32'd1);
        check("stop_txd", 32'(bus.uart_tx_data), 32'h00);
        check("stop_cpu_rdy", 32'(bus.cpu_rdy), 32'd0);
        drive(32'h30000, 1'b1, 8'h77);
        step();
        drive(32'h00100, 1'b1, 8'hCD);
        step();
        drive(32'h00100, 1'b0, 8'h00);
        step();
        check("halt_ram_drop", 32'(bus.mem_din), 32'hAB);
        bus.uart_tx_ready = 1'b1;
        step();
        check("halt_io_drop", 32'(bus.uart_tx_valid), 32'd0);
        check("halt_stays", 32'(bus.cpu_rdy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
